uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver that directly feeds echo_mode's receive path.
- Samples the asynchronous `rxd` line, validates start/stop framing, and presents each byte on `word` with a `recieve_ready` valid flag.
- The flag is held until the consumer acknowledges it.
- A one-byte holding register is included, with sticky overrun and one-cycle framing-error indications.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); must be even and >= 8.
- CNT_W, 13, counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- rxd  in  1  serial input, asynchronous to clk, idles high.
- recieve_ack  in  1  consumer has taken `word`; sampled on the rising edge.
- word  out  8  last received byte, LSB first on the line.
- recieve_ready  out  1  `word` holds an unacknowledged byte.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  sticky flag: a byte was dropped because `recieve_ready` was still set.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous), all registers forced as follows:
  - word=8'h00, recieve_ready=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE, counters=0, shift=0.
  - Both synchronizer flops = 1 (line idle).
- Reset mid-frame aborts the frame immediately; no partial byte is ever delivered.
- Synchronizer: two flops on `rxd` produce rxd_s. All decisions use rxd_s only, giving 2 cycles of input latency.
- The bit counter `cnt` (CNT_W bits) and bit index `idx` (3 bits) are internal.
- State machine (registered), states IDLE, START, DATA, STOP, BREAK:
  - IDLE: when rxd_s=0, go to START with cnt=0.
  - START: increment cnt. At cnt=CLKS_PER_BIT/2-1, sample rxd_s:
    - 0: go to DATA with cnt=0, idx=0.
    - 1: glitch; return to IDLE with no flags.
  - DATA: increment cnt. At cnt=CLKS_PER_BIT-1:
    - Shift right, loading rxd_s into bit 7 (LSB first on the line), and set cnt=0.
    - If idx=7, go to STOP; otherwise idx+1.
  - STOP: increment cnt. At cnt=CLKS_PER_BIT-1, sample rxd_s:
    - 1, valid frame: deliver (see delivery rules); go to IDLE.
    - 0: frame_err=1 for exactly one cycle; byte discarded, `word` unchanged; go to BREAK.
  - BREAK: wait until rxd_s=1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Sampling points, with the falling edge of rxd_s as cycle 0:
  - Start bit sampled at cycle CLKS_PER_BIT/2.
  - Data bit k sampled at CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
  - Stop bit sampled at CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
  - `recieve_ready` rises on the cycle after the stop sample.
- Delivery rules (valid stop bit):
  - recieve_ready=0, or recieve_ack=1 on the same edge: word<=shift, recieve_ready<=1.
  - recieve_ready=1 and recieve_ack=0: byte dropped; `word` is kept; overrun<=1.
- Acknowledge rules:
  - recieve_ack=1 while recieve_ready=1: recieve_ready<=0 and overrun<=0 next cycle, unless the same-edge delivery above applies, in which case recieve_ready stays 1 with the new word.
  - recieve_ack while recieve_ready=0: ignored.
- recieve_ack may be held high continuously. Each byte is then seen as a single-cycle `recieve_ready` pulse.
- Back-to-back frames: a new start bit is detected in IDLE one cycle after the stop decision, so no inter-frame gap beyond the stop bit is required.

Test Plan:
- Common setup: CLKS_PER_BIT=16 and rst pulsed low for 3 cycles; outputs checked during and after reset.
- Reset values: during reset word=00, recieve_ready=0, overrun=0, frame_err=0, busy=0; after release they hold with rxd=1.
- Single byte: send 8'hA5 (line 0,1,0,1,0,0,1,0,1,1) -> `recieve_ready` rises exactly 2+8+144+1 cycles after the rxd falling edge, word=A5; ack -> ready 0 next cycle.
- Glitch: rxd low for 4 cycles, then high -> back to IDLE, no ready, no frame_err, busy drops after 8 cycles.
- Framing error: 8'h3C with stop bit 0, then line held low for 40 cycles -> frame_err high for 1 cycle, word unchanged, no new frame until rxd returns high.
- Overrun: send 8'h11 without ack, then 8'h22 -> word=11, overrun=1; ack -> ready=0, overrun=0. With continuous ack, 8'h55 then 8'hAA -> two 1-cycle ready pulses with words 55 and AA, overrun stays 0.
- Reset mid-frame: assert rst during DATA bit 4 of 8'hFF -> all outputs reset immediately; a following 8'h0F is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-byte holding register.
//
// Ports:
//   clk           system clock; all logic runs on the rising edge
//   rst           asynchronous active-low reset
//   rxd           serial input, asynchronous to clk, idles high
//   recieve_ack   consumer has taken word (sampled on the rising edge)
//   word          last delivered byte (LSB first on the line)
//   recieve_ready word holds an unacknowledged byte
//   frame_err     one-cycle pulse when the stop bit is sampled low
//   overrun       sticky: a byte was dropped while recieve_ready was set
//   busy          receiver is in any state other than IDLE
//
// rxd passes through a two-flop synchronizer. The start bit is re-checked
// at mid-bit, so every data and stop sample lands near the bit centre.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       recieve_ack,
    output logic [7:0] word,
    output logic       recieve_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    logic             sync1, rxd_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;

    assign busy = (state != IDLE);

    // Synchronizer resets to 1 so that reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            word          <= 8'h00;
            recieve_ready <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            // Acknowledge first; a same-edge delivery below overrides the clear.
            if (recieve_ack && recieve_ready) begin
                recieve_ready <= 1'b0;
                overrun       <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        idx <= '0;
                        // A line that is high again at mid-bit was only a glitch.
                        state <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shift <= {rxd_s, shift[7:1]};
                        if (idx == 3'd7) state <= STOP;
                        else             idx   <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= IDLE;
                            if (!recieve_ready || recieve_ack) begin
                                word          <= shift;
                                recieve_ready <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            // Bad stop bit: drop the byte and wait out a held-low line.
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rxd_s) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
